// File: rtl/muldiv_unit.sv
// MIPS multiply/divide unit holding the architectural HI/LO registers.
// Multiply uses a combinational product released after MUL_LAT cycles; divide is a 34-cycle restoring divider.
module muldiv_unit #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {IDLE, MUL, DIV_SETUP, DIV_ITER, DIV_FIX} state_t;

  state_t      state;
  logic        uns_q;
  logic [31:0] a_q, b_q;
  logic [2:0]  mul_cnt;
  logic [4:0]  iter_cnt;
  logic [31:0] rem, quo, dvsr;

  logic [63:0] ext_a, ext_b, prod;
  logic        sgn;
  logic [31:0] abs_a, abs_b;
  logic [32:0] rem_sh;
  logic        ge;
  logic [31:0] rem_next, q_fix, r_fix;

  always_comb begin
    sgn      = ~uns_q;
    ext_a    = {{32{sgn & a_q[31]}}, a_q};
    ext_b    = {{32{sgn & b_q[31]}}, b_q};
    prod     = ext_a * ext_b;
    abs_a    = (sgn & a_q[31]) ? -a_q : a_q;
    abs_b    = (sgn & b_q[31]) ? -b_q : b_q;
    // Quotient register starts as the dividend; its MSB feeds the partial remainder.
    rem_sh   = {rem, quo[31]};
    ge       = rem_sh >= {1'b0, dvsr};
    rem_next = ge ? 32'(rem_sh - {1'b0, dvsr}) : rem_sh[31:0];
    q_fix    = (sgn & (a_q[31] ^ b_q[31])) ? -quo : quo;
    r_fix    = (sgn & a_q[31]) ? -rem : rem;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      uns_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      mul_cnt  <= '0;
      iter_cnt <= '0;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            uns_q <= op[0];
            a_q   <= rs_data;
            b_q   <= rt_data;
            busy  <= 1'b1;
            if (op[1]) begin
              state <= DIV_SETUP;
            end else begin
              state   <= MUL;
              mul_cnt <= 3'(MUL_LAT - 1);
            end
          end else begin
            if (wr_hi) hi <= rs_data;
            if (wr_lo) lo <= rt_data;
          end
        end
        MUL: begin
          if (mul_cnt == 3'd0) begin
            hi    <= prod[63:32];
            lo    <= prod[31:0];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            mul_cnt <= mul_cnt - 3'd1;
          end
        end
        DIV_SETUP: begin
          rem      <= '0;
          quo      <= abs_a;
          dvsr     <= abs_b;
          iter_cnt <= 5'd31;
          state    <= DIV_ITER;
        end
        DIV_ITER: begin
          rem <= rem_next;
          quo <= {quo[30:0], ge};
          if (iter_cnt == 5'd0) state <= DIV_FIX;
          else iter_cnt <= iter_cnt - 5'd1;
        end
        DIV_FIX: begin
          // A zero divisor bypasses the iteration result entirely.
          if (b_q == 32'd0) begin
            hi <= a_q;
            lo <= 32'hFFFF_FFFF;
          end else begin
            hi <= r_fix;
            lo <= q_fix;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
